// File: rtl/fp_pkg.sv
// fp_pkg: types and helpers shared by the FP compare issue controller.
//   - op encodings for the compare/min/max request field
//   - canonical quiet NaN returned by FMIN/FMAX when both inputs are NaN
//   - is_nan / is_zero classifiers on raw IEEE single bit patterns
//   - fp_cmp_req_t: one request as it travels beside the compare core
package fp_pkg;

  localparam logic [2:0] FP_OP_FEQ  = 3'd0;
  localparam logic [2:0] FP_OP_FLT  = 3'd1;
  localparam logic [2:0] FP_OP_FLE  = 3'd2;
  localparam logic [2:0] FP_OP_FMIN = 3'd3;
  localparam logic [2:0] FP_OP_FMAX = 3'd4;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  // Width of the tag field carried in fp_cmp_req_t. Tags narrower than this
  // are zero-extended on entry; a wider TAG_W would lose its upper bits.
  localparam int FP_TAG_W = 5;

  typedef struct packed {
    logic [2:0]          op;
    logic [FP_TAG_W-1:0] tag;
    logic [31:0]         a;
    logic [31:0]         b;
  } fp_cmp_req_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  // +0 and -0 both count as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fp_compare_resp_fifo.sv
// fp_compare_resp_fifo: DEPTH-entry result FIFO between the compare tail and
// writeback. Head is read straight from storage, so a push into an empty FIFO
// shows up the cycle after the write, and the head stays put until popped.
//   clk, areset   clock, async active-low reset (pointers and count only)
//   push, wdata   write one entry (ignored when full with no pop)
//   pop           remove head (ignored when empty)
//   head          current head entry
//   count         occupancy, 0..DEPTH
module fp_compare_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fp_compare_issue.sv
// fp_compare_issue: issue/response wrapper around a fixed-latency FP a<=b core.
// Requests are accepted on a valid/ready handshake, operands go straight to the
// core, and {op, tag, a, b} ride a side pipeline so that the tail stage lines
// up with the core's 1-bit result. The tail turns that bit into FEQ/FLT/FLE/
// FMIN/FMAX and pushes {result, tag} into a small FIFO. Acceptance is gated by
// credits (in-flight + queued < DEPTH), so the FIFO cannot overflow and the
// side pipeline never stalls.
//   clk, areset                   clock, async active-low reset
//   in_valid/in_ready             request handshake
//   in_op/in_a/in_b/in_tag        request payload
//   cmp_a/cmp_b                   operands to the core (sampled every cycle)
//   cmp_q                         core result, LATENCY cycles after cmp_a/cmp_b
//   out_valid/out_ready           result handshake
//   out_result/out_tag            result payload
module fp_compare_issue
  import fp_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = LATENCY - 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int IW     = $clog2(LATENCY + 1);

  logic             live;      // low during reset and for the first edge after
  logic             fire;
  logic [STAGES:0]  vld_pipe;
  fp_cmp_req_t      req_pipe [STAGES+1];
  fp_cmp_req_t      req_in, tail;
  logic [IW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic             nan_a, nan_b, zeros_eq, eq;
  logic [31:0]      result;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      head_result;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) live <= 1'b0;
    else         live <= 1'b1;
  end

  // The core sees the request operands every cycle; reset forces them to 0.
  assign cmp_a = live ? in_a : '0;
  assign cmp_b = live ? in_b : '0;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= STAGES; i++) inflight = inflight + IW'(vld_pipe[i]);
  end

  // Pops this cycle are not credited: keeps in_ready free of out_ready.
  assign in_ready = live && ((32'(inflight) + 32'(fifo_count)) < 32'(DEPTH));
  assign fire     = in_valid && in_ready;

  assign req_in = '{op: in_op, tag: FP_TAG_W'(in_tag), a: in_a, b: in_b};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= fire;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Payload needs no reset: only the valid bits qualify it.
  always_ff @(posedge clk) begin
    req_pipe[0] <= req_in;
    for (int i = 1; i <= STAGES; i++) req_pipe[i] <= req_pipe[i-1];
  end

  assign tail = req_pipe[STAGES];

  always_comb begin
    nan_a    = is_nan(tail.a);
    nan_b    = is_nan(tail.b);
    zeros_eq = is_zero(tail.a) && is_zero(tail.b);
    eq       = !nan_a && !nan_b && ((tail.a == tail.b) || zeros_eq);
    result   = '0;
    case (tail.op)
      FP_OP_FEQ: result = {31'b0, eq};
      FP_OP_FLT: result = {31'b0, cmp_q && !eq};
      FP_OP_FLE: result = {31'b0, cmp_q};
      FP_OP_FMIN, FP_OP_FMAX: begin
        if (nan_a && nan_b)  result = FP_CANON_NAN;
        else if (nan_a)      result = tail.b;
        else if (nan_b)      result = tail.a;
        // Signed zeros compare equal; pick the sign from the bit patterns.
        else if (zeros_eq)   result = (tail.op == FP_OP_FMIN) ? (tail.a | tail.b)
                                                              : (tail.a & tail.b);
        else if (tail.op == FP_OP_FMIN) result = cmp_q ? tail.a : tail.b;
        else                            result = cmp_q ? tail.b : tail.a;
      end
      default: result = '0;
    endcase
  end

  fp_compare_resp_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + TAG_W)
  ) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (vld_pipe[STAGES]),
    .wdata ({result, tail.tag[TAG_W-1:0]}),
    .pop   (out_valid && out_ready),
    .head  ({head_result, head_tag}),
    .count (fifo_count)
  );

  assign out_valid  = fifo_count != '0;
  assign out_result = head_result;
  assign out_tag    = head_tag;

endmodule

// File: tb/tb_fp_compare_issue.sv
module tb_fp_compare_issue;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;
  localparam int DEPTH   = 4;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [31:0]      in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      cmp_a, cmp_b;
  logic             cmp_q;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  fp_compare_issue #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_q(cmp_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic m_zero(input logic [31:0] x);
    return (x & 32'h7FFF_FFFF) == 0;
  endfunction

  // Maps IEEE bit patterns onto an unsigned key with the same numeric order.
  function automatic logic [31:0] okey(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic m_le(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return 1'b0;
    if (m_zero(a) && m_zero(b)) return 1'b1;
    return okey(a) <= okey(b);
  endfunction

  function automatic logic m_eq(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return 1'b0;
    return (a == b) || (m_zero(a) && m_zero(b));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic na, nb;
    na = m_nan(a);
    nb = m_nan(b);
    case (op)
      3'd0: return {31'b0, m_eq(a, b)};
      3'd1: return {31'b0, m_le(a, b) && !m_eq(a, b)};
      3'd2: return {31'b0, m_le(a, b)};
      3'd3, 3'd4: begin
        if (na && nb) return 32'h7FC0_0000;
        if (na) return b;
        if (nb) return a;
        if (m_zero(a) && m_zero(b)) return (op == 3'd3) ? (a | b) : (a & b);
        if (op == 3'd3) return m_le(a, b) ? a : b;
        return m_le(a, b) ? b : a;
      end
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- core model: a<=b, LATENCY cycles late ----------------
  logic [LATENCY-1:0] qpipe;
  always @(posedge clk) begin
    qpipe[0] <= m_le(cmp_a, cmp_b);
    for (int i = 1; i < LATENCY; i++) qpipe[i] <= qpipe[i-1];
  end
  assign cmp_q = qpipe[LATENCY-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               rdy;   // first cycle the result may be visible
  } exp_t;
  exp_t q[$];
  int   cur = 0;
  logic dut_fire;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cur);
    end
  endtask

  // One cycle: check outputs mid-cycle, then drive this cycle's inputs.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic ordy,
                      input logic use_want, input logic [31:0] want);
    logic exp_ready, exp_valid;
    @(negedge clk);
    exp_ready = q.size() < DEPTH;
    exp_valid = (q.size() > 0) && (q[0].rdy <= cur);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = ordy;
    dut_fire  = v && in_ready;
    if (exp_valid && ordy) void'(q.pop_front());
    if (v && exp_ready) q.push_back('{use_want ? want : ref_result(op, a, b), tag, cur + LATENCY + 1});
    cur++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'h0, 32'h0, '0, ordy, 1'b0, 32'h0);
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAG_W-1:0] tag, input logic [31:0] want);
    step(1'b1, op, a, b, tag, 1'b1, 1'b1, want);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 16)
      0: return 32'h0000_0000;  1: return 32'h8000_0000;
      2: return 32'h3F80_0000;  3: return 32'hBF80_0000;
      4: return 32'h4000_0000;  5: return 32'h7F80_0000;
      6: return 32'hFF80_0000;  7: return 32'h7FC0_0000;
      8: return 32'hFFC0_0001;  9: return 32'h7F80_0001;
      10: return 32'h0000_0001; 11: return 32'h8000_0001;
      default: return $urandom;
    endcase
  endfunction

  int acc;
  int pops;

  initial begin
    // Reset state, asynchronous: visible before any clock edge.
    in_a = 32'h3F80_0000;
    #1 areset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_cmp_a", cmp_a, 32'h0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;

    // Single FLT / FEQ on 1.0 vs 2.0, latency checked by the cycle model.
    req(3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd1, 32'h1);
    idle(3, 1'b1);
    req(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd2, 32'h0);
    idle(4, 1'b1);

    // NaN and signed-zero rules for FMIN/FMAX.
    req(3'd3, 32'h7FC0_0000, 32'h4000_0000, 5'd3, 32'h4000_0000);
    req(3'd3, 32'h7FC0_0000, 32'hFFC0_0001, 5'd4, 32'h7FC0_0000);
    req(3'd4, 32'h8000_0000, 32'h0000_0000, 5'd5, 32'h0000_0000);
    req(3'd3, 32'h8000_0000, 32'h0000_0000, 5'd6, 32'h8000_0000);
    // FEQ/FLE/FLT edge cases and a reserved op.
    req(3'd0, 32'h8000_0000, 32'h0000_0000, 5'd7, 32'h1);
    req(3'd2, 32'h7FC0_0000, 32'h3F80_0000, 5'd8, 32'h0);
    req(3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd9, 32'h0);
    req(3'd6, 32'h3F80_0000, 32'h4000_0000, 5'd10, 32'h0);
    idle(6, 1'b1);

    // Backpressure: exactly DEPTH accepts, then in-order drain.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd1, 32'h3F80_0000, 32'h4000_0000, TAG_W'(acc), 1'b0, 1'b0, 32'h0);
      if (dut_fire) acc++;
    end
    chk("bp_accepts", 32'(acc), 32'(DEPTH));
    idle(8, 1'b1);

    // Streaming: 16 back-to-back with out_ready high.
    pops = 0;
    for (int i = 0; i < 16 + LATENCY + 1; i++) begin
      if (i < 16) step(1'b1, 3'($urandom % 5), pick(), pick(), TAG_W'(i), 1'b1, 1'b0, 32'h0);
      else        idle(1, 1'b1);
      if (out_valid) pops++;
    end
    chk("stream_pops", 32'(pops), 32'd16);
    idle(4, 1'b1);

    // Random traffic with random backpressure, including reserved ops.
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, 3'($urandom % 8), pick(), pick(), TAG_W'($urandom),
           ($urandom % 3) != 0, 1'b0, 32'h0);
    idle(10, 1'b1);

    // Reset with two requests in flight and one queued.
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd3, pick(), pick(), TAG_W'(20 + i), 1'b0, 1'b0, 32'h0);
    idle(1, 1'b0);
    in_a   = 32'h3F80_0000;
    areset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    chk("midrst_cmp_a", cmp_a, 32'h0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    cur += 2;
    areset = 1'b1;
    idle(6, 1'b1);
    req(3'd4, 32'hBF80_0000, 32'h3F80_0000, 5'd30, 32'h3F80_0000);
    idle(5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
